// File: rtl/lock_array_pkg.sv
// Shared types for the lock channel array: per-channel state encoding and the
// counter width helper.
package lock_array_pkg;

    typedef enum logic [1:0] {
        STATE_CLOSED  = 2'd0,
        STATE_OPENING = 2'd1,
        STATE_OPENED  = 2'd2,
        STATE_CLOSING = 2'd3
    } state;

    // Wide enough for the largest reload value plus a spare bit.
    function automatic int count_width(input int open_cycles,
                                       input int close_cycles,
                                       input int hold_cycles);
        int m;
        m = 1;
        if (open_cycles > m)  m = open_cycles;
        if (close_cycles > m) m = close_cycles;
        if (hold_cycles > m)  m = hold_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lock_channel.sv
// One lock channel: CLOSED/OPENING/OPENED/CLOSING machine with a shared
// down-counter used for travel time and the auto-close hold timer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// CLOSED  | at rest, waits for open (blocked by lockout)
// OPENING | travelling open for OPEN_CYCLES cycles; close/lockout ignored
// OPENED  | open; close/lockout/hold timeout start closing, open re-arms
// CLOSING | travelling closed for CLOSE_CYCLES cycles; obstruct reverses
module lock_channel
    import lock_array_pkg::*;
#(
    parameter int OPEN_CYCLES  = 1,
    parameter int CLOSE_CYCLES = 1,
    parameter int HOLD_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       open,
    input  logic       close,
    input  logic       obstruct,
    input  logic       lockout,
    output logic [1:0] chan_state,
    output logic       opened,
    output logic       closed,
    output logic       auto_close
);

    localparam int CW = count_width(OPEN_CYCLES, CLOSE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] CLOSE_LOAD = CW'(CLOSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = (HOLD_CYCLES == 0) ? '0 : CW'(HOLD_CYCLES - 1);
    localparam logic          HOLD_EN    = (HOLD_CYCLES != 0);

    state          cur_st, nxt_st;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          nxt_auto;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st     <= STATE_CLOSED;
            cnt        <= '0;
            auto_close <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            cnt        <= nxt_cnt;
            auto_close <= nxt_auto;
        end
    end

    always_comb begin
        nxt_st   = cur_st;
        nxt_cnt  = cnt;
        nxt_auto = 1'b0;
        case (cur_st)
            STATE_CLOSED: begin
                if (open && !lockout) begin
                    nxt_st  = STATE_OPENING;
                    nxt_cnt = OPEN_LOAD;
                end
            end
            STATE_OPENING: begin
                if (cnt == '0) begin
                    nxt_st  = STATE_OPENED;
                    nxt_cnt = HOLD_LOAD;
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            STATE_OPENED: begin
                if (close || lockout) begin
                    nxt_st  = STATE_CLOSING;
                    nxt_cnt = CLOSE_LOAD;
                end else if (open) begin
                    nxt_cnt = HOLD_LOAD;
                end else if (HOLD_EN && cnt == '0) begin
                    nxt_st   = STATE_CLOSING;
                    nxt_cnt  = CLOSE_LOAD;
                    nxt_auto = 1'b1;
                end else if (HOLD_EN) begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            STATE_CLOSING: begin
                // Reversal beats both completion and lockout.
                if (obstruct) begin
                    nxt_st  = STATE_OPENING;
                    nxt_cnt = OPEN_LOAD;
                end else if (cnt == '0) begin
                    nxt_st = STATE_CLOSED;
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            default: begin
                nxt_st  = STATE_CLOSED;
                nxt_cnt = '0;
            end
        endcase
    end

    always_comb begin
        chan_state = cur_st;
        opened     = (cur_st == STATE_OPENED);
        closed     = (cur_st == STATE_CLOSED);
    end

endmodule

// File: rtl/lock_array.sv
// Array of independent lock channels sharing clock, reset and global lockout.
module lock_array
    import lock_array_pkg::*;
#(
    parameter int N_LOCKS      = 4,
    parameter int OPEN_CYCLES  = 1,
    parameter int CLOSE_CYCLES = 1,
    parameter int HOLD_CYCLES  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_LOCKS-1:0]   open,
    input  logic [N_LOCKS-1:0]   close,
    input  logic [N_LOCKS-1:0]   obstruct,
    input  logic                 lockout,
    output logic [2*N_LOCKS-1:0] state,
    output logic [N_LOCKS-1:0]   opened,
    output logic [N_LOCKS-1:0]   closed,
    output logic [N_LOCKS-1:0]   auto_close
);

    for (genvar i = 0; i < N_LOCKS; i++) begin : g_chan
        lock_channel #(
            .OPEN_CYCLES  (OPEN_CYCLES),
            .CLOSE_CYCLES (CLOSE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .open       (open[i]),
            .close      (close[i]),
            .obstruct   (obstruct[i]),
            .lockout    (lockout),
            .chan_state (state[2*i +: 2]),
            .opened     (opened[i]),
            .closed     (closed[i]),
            .auto_close (auto_close[i])
        );
    end

endmodule

// File: tb/tb_lock_array.sv
// Directed bench for lock_array: a default-parameter instance and one with
// OPEN=3, CLOSE=2, HOLD=5.
module tb_lock_array;

    localparam logic [1:0] CL = 2'd0, OPG = 2'd1, OPD = 2'd2, CLG = 2'd3;

    logic       clk;
    logic       rst;
    logic [3:0] d_open, d_close, d_obstruct;
    logic       d_lockout;
    logic [7:0] d_state;
    logic [3:0] d_opened, d_closed, d_auto;
    logic [3:0] p_open, p_close, p_obstruct;
    logic       p_lockout;
    logic [7:0] p_state;
    logic [3:0] p_opened, p_closed, p_auto;

    int checks = 0;
    int errors = 0;

    lock_array #(.N_LOCKS(4)) u_def (
        .clk(clk), .rst(rst), .open(d_open), .close(d_close), .obstruct(d_obstruct),
        .lockout(d_lockout), .state(d_state), .opened(d_opened), .closed(d_closed),
        .auto_close(d_auto)
    );

    lock_array #(.N_LOCKS(4), .OPEN_CYCLES(3), .CLOSE_CYCLES(2), .HOLD_CYCLES(5)) u_par (
        .clk(clk), .rst(rst), .open(p_open), .close(p_close), .obstruct(p_obstruct),
        .lockout(p_lockout), .state(p_state), .opened(p_opened), .closed(p_closed),
        .auto_close(p_auto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] e;
        d_open = '0; d_close = '0; d_obstruct = '0; d_lockout = 1'b0;
        p_open = '0; p_close = '0; p_obstruct = '0; p_lockout = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("init_state", d_state, 8'h00);
        check("init_closed", d_closed, 4'hF);
        @(negedge clk) rst = 1'b1;
        tick();

        // Reset mid-operation, asynchronous
        d_open = 4'b0001; p_open = 4'hF;
        tick();
        d_open = '0; p_open = '0;
        check("def_opening", d_state[1:0], OPG);
        check("def_opening_opened", d_opened, 4'b0000);
        tick();
        check("def_opened", d_state[1:0], OPD);
        check("def_opened_vec", d_opened, 4'b0001);
        check("def_closed_vec", d_closed, 4'b1110);
        check("par_busy", p_state, 8'h55);
        #2 rst = 1'b0;
        #1;
        check("rst_def_state", d_state, 8'h00);
        check("rst_def_closed", d_closed, 4'hF);
        check("rst_def_opened", d_opened, 4'h0);
        check("rst_def_auto", d_auto, 4'h0);
        check("rst_par_state", p_state, 8'h00);
        check("rst_par_closed", p_closed, 4'hF);
        @(negedge clk) rst = 1'b1;
        tick();

        // Default sequence: one-cycle OPENING and CLOSING
        d_open = 4'b0001;
        tick();
        d_open = '0;
        check("seq_opening", d_state[1:0], OPG);
        tick();
        check("seq_opened", d_state[1:0], OPD);
        tick();
        check("seq_no_autoclose", d_state[1:0], OPD);
        d_close = 4'b0001;
        tick();
        d_close = '0;
        check("seq_closing", d_state[1:0], CLG);
        tick();
        check("seq_closed", d_state, 8'h00);

        // Lockout: ch0/ch2 open, open[1] with lockout
        d_open = 4'b0101;
        tick();
        d_open = '0;
        tick();
        check("lk_pre", d_state, 8'h22);
        d_lockout = 1'b1; d_open = 4'b0010;
        tick();
        check("lk_closing", d_state, 8'h33);
        check("lk_closed_vec", d_closed, 4'b1010);
        tick();
        check("lk_all_closed", d_state, 8'h00);
        d_lockout = 1'b0; d_open = '0;

        // Obstruct in CLOSED has no effect
        d_obstruct = 4'hF;
        tick();
        check("obs_closed", d_state, 8'h00);
        d_obstruct = '0;

        // Priority: open+close on ch0 in OPENED, ch3 opens alongside
        d_open = 4'b0001;
        tick();
        d_open = '0;
        tick();
        d_open = 4'b1001; d_close = 4'b0001;
        tick();
        d_open = '0; d_close = '0;
        check("pri_close_wins", d_state, 8'h43);
        tick();
        check("pri_indep", d_state, 8'h80);
        check("pri_opened", d_opened, 4'b1000);
        tick();
        tick();
        check("pri_hold0_state", d_state, 8'h80);
        check("pri_hold0_auto", d_auto, 4'h0);
        d_close = 4'b1000;
        tick();
        d_close = '0;
        tick();
        check("pri_end", d_closed, 4'hF);

        // Travel timing on ch1: OPEN=3, CLOSE=2
        for (int c = 1; c <= 9; c++) begin
            p_open  = (c == 1) ? 4'b0010 : 4'b0000;
            p_close = (c == 7) ? 4'b0010 : 4'b0000;
            tick();
            e = (c <= 3) ? OPG : (c <= 6) ? OPD : (c <= 8) ? CLG : CL;
            check($sformatf("travel_c%0d", c), p_state[3:2], e);
            check($sformatf("travel_auto_c%0d", c), p_auto, 4'h0);
        end
        p_open = '0; p_close = '0;

        // Auto-close on ch2: HOLD=5
        for (int c = 1; c <= 11; c++) begin
            p_open = (c == 1) ? 4'b0100 : 4'b0000;
            tick();
            e = (c <= 3) ? OPG : (c <= 8) ? OPD : (c <= 10) ? CLG : CL;
            check($sformatf("auto_c%0d", c), p_state[5:4], e);
            check($sformatf("auto_pulse_c%0d", c), p_auto, (c == 9) ? 4'b0100 : 4'b0000);
        end

        // Hold restart: open again in hold cycle 3 (0-based) delays close by 4
        for (int c = 1; c <= 15; c++) begin
            p_open = (c == 1 || c == 8) ? 4'b0100 : 4'b0000;
            tick();
            e = (c <= 3) ? OPG : (c <= 12) ? OPD : (c <= 14) ? CLG : CL;
            check($sformatf("restart_c%0d", c), p_state[5:4], e);
            check($sformatf("restart_pulse_c%0d", c), p_auto, (c == 13) ? 4'b0100 : 4'b0000);
        end
        p_open = '0;

        // Obstruction on ch3 at the last CLOSING cycle, then held while OPENED
        for (int c = 1; c <= 12; c++) begin
            p_open     = (c == 1) ? 4'b1000 : 4'b0000;
            p_close    = (c == 5) ? 4'b1000 : 4'b0000;
            p_obstruct = (c >= 7) ? 4'b1000 : 4'b0000;
            tick();
            e = (c <= 3) ? OPG : (c == 4) ? OPD : (c <= 6) ? CLG : (c <= 9) ? OPG : OPD;
            check($sformatf("obstruct_c%0d", c), p_state[7:6], e);
        end
        p_obstruct = '0; p_close = 4'b1000;
        tick();
        p_close = '0;
        tick();
        tick();
        check("obstruct_end", p_closed, 4'hF);

        // Lockout raised while ch0 is OPENING: completes, then closes
        for (int c = 1; c <= 8; c++) begin
            p_open    = (c == 1 || c == 8) ? 4'b0001 : 4'b0000;
            p_lockout = (c >= 2);
            tick();
            e = (c <= 3) ? OPG : (c == 4) ? OPD : (c <= 6) ? CLG : CL;
            check($sformatf("lk_opening_c%0d", c), p_state[1:0], e);
        end
        p_open = '0; p_lockout = 1'b0;
        check("final_par_closed", p_closed, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
